// File: rtl/ram_pkg.sv
// Shared constants and byte-merge helper for the byte-enabled multi-read-port RAM.
package ram_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MAX_RD = 4;

  function automatic logic [BYTE_W-1:0] merge_byte(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              en
  );
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/ram_rd_port.sv
// One registered read port: output data register, valid flag and write-first merge.
// Collision behaviour selected by macro RAM_BYPASS_EN (write-first) vs default read-first.
module ram_rd_port
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     re_i,
  input  logic [ADDR_WIDTH-1:0]    raddr_i,
  input  logic [DATA_WIDTH-1:0]    rdata_i,
  input  logic                     we_i,
  input  logic [ADDR_WIDTH-1:0]    waddr_i,
  input  logic [DATA_WIDTH/8-1:0]  be_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic [DATA_WIDTH-1:0]    q_o,
  output logic                     valid_o
);

  localparam int unsigned NB = DATA_WIDTH / BYTE_W;

`ifdef RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  valid_q, valid_d;
  logic                  hit;

  always_comb begin
    hit     = BYPASS && we_i && (waddr_i == raddr_i);
    q_d     = q_q;
    valid_d = re_i;
    if (re_i) begin
      q_d = rdata_i;
      // rdata_i is the pre-write word; overlay enabled bytes for write-first.
      if (hit) begin
        for (int unsigned b = 0; b < NB; b++) begin
          q_d[b*BYTE_W +: BYTE_W] = merge_byte(rdata_i[b*BYTE_W +: BYTE_W],
                                               wdata_i[b*BYTE_W +: BYTE_W], be_i[b]);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = q_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ram_dp_be.sv
// Byte-enabled RAM with one write port and NUM_RD registered read ports.
// Optional macro RAM_BYPASS_EN makes same-address read/write collisions write-first.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RD     = 2
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           ENABLE_W,
  input  logic [ADDR_WIDTH-1:0]          ADDR_W,
  input  logic [DATA_WIDTH/8-1:0]        BE_W,
  input  logic [DATA_WIDTH-1:0]          Q_W,
  input  logic [NUM_RD-1:0]              RE_R,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   ADDR_R,
  output logic [NUM_RD*DATA_WIDTH-1:0]   Q_R,
  output logic [NUM_RD-1:0]              VALID_R
);

  localparam int unsigned NB    = DATA_WIDTH / BYTE_W;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("ram_dp_be: DATA_WIDTH must be a multiple of 8");
  end
  if (NUM_RD < 1 || NUM_RD > MAX_RD) begin : g_bad_nrd
    $error("ram_dp_be: NUM_RD must be in 1..4");
  end

  // Storage is deliberately never reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (!RESET && ENABLE_W) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (BE_W[b]) begin
          mem_q[ADDR_W][b*BYTE_W +: BYTE_W] <= Q_W[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rd_word;

    assign raddr   = ADDR_R[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_word = mem_q[raddr];

    ram_rd_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_port (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .re_i    (RE_R[p]),
      .raddr_i (raddr),
      .rdata_i (rd_word),
      .we_i    (ENABLE_W),
      .waddr_i (ADDR_W),
      .be_i    (BE_W),
      .wdata_i (Q_W),
      .q_o     (Q_R[p*DATA_WIDTH +: DATA_WIDTH]),
      .valid_o (VALID_R[p])
    );
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed self-checking bench for ram_dp_be (2 read ports, 32-bit words).
module tb_ram_dp_be;

`ifdef RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, we;
  logic [9:0]  waddr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [1:0]  re;
  logic [19:0] raddr;
  logic [63:0] q;
  logic [1:0]  valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_dp_be #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32),
    .NUM_RD     (2)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .ENABLE_W (we),
    .ADDR_W   (waddr),
    .BE_W     (be),
    .Q_W      (wdata),
    .RE_R     (re),
    .ADDR_R   (raddr),
    .Q_R      (q),
    .VALID_R  (valid)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [9:0]  waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  re;
    logic [9:0]  ra0;
    logic [9:0]  ra1;
    logic [1:0]  ev;
    logic [31:0] eq0;
    logic [31:0] eq1;
  } vec_t;

  vec_t vec[$];

  task automatic add(input logic r, input logic w, input logic [9:0] wa, input logic [3:0] b,
                     input logic [31:0] wd, input logic [1:0] rr, input logic [9:0] a0,
                     input logic [9:0] a1, input logic [1:0] ev, input logic [31:0] e0,
                     input logic [31:0] e1);
    vec_t v;
    v = '{rst: r, we: w, waddr: wa, be: b, wdata: wd, re: rr, ra0: a0, ra1: a1,
          ev: ev, eq0: e0, eq1: e1};
    vec.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [9:0] wa, input logic [3:0] b,
                       input logic [31:0] wd, input logic [1:0] rr, input logic [9:0] a0,
                       input logic [9:0] a1);
    rst = r; we = w; waddr = wa; be = b; wdata = wd; re = rr;
    raddr = {a1, a0};
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int unsigned a);
    return 32'h10203040 + a * 32'h01010101;
  endfunction

  initial begin
    logic [31:0] coll7, coll5;
    coll7 = BYP ? 32'h12345678 : 32'h00000000;
    coll5 = BYP ? 32'h5522CC44 : 32'h1122CC44;

    rst = 1'b1; we = 1'b0; waddr = '0; be = '0; wdata = '0; re = '0; raddr = '0;

    //  rst we wa  be     wdata          re    a0 a1  ev    eq0            eq1
    add(1, 0, 0,  4'h0, 32'h0,         2'b00, 0, 0, 2'b00, 32'h0,         32'h0);
    add(0, 1, 3,  4'hF, 32'hDEADBEEF,  2'b00, 0, 0, 2'b00, 32'h0,         32'h0);
    add(0, 0, 0,  4'h0, 32'h0,         2'b01, 3, 0, 2'b01, 32'hDEADBEEF,  32'h0);
    add(0, 1, 5,  4'hF, 32'h11223344,  2'b00, 0, 0, 2'b00, 32'hDEADBEEF,  32'h0);
    add(0, 1, 5,  4'h2, 32'hAABBCCDD,  2'b00, 0, 0, 2'b00, 32'hDEADBEEF,  32'h0);
    add(0, 0, 0,  4'h0, 32'h0,         2'b01, 5, 0, 2'b01, 32'h1122CC44,  32'h0);
    add(0, 1, 7,  4'hF, 32'h0,         2'b00, 0, 0, 2'b00, 32'h1122CC44,  32'h0);
    add(0, 1, 7,  4'hF, 32'h12345678,  2'b01, 7, 0, 2'b01, coll7,         32'h0);
    add(0, 0, 0,  4'h0, 32'h0,         2'b01, 7, 0, 2'b01, 32'h12345678,  32'h0);
    add(0, 1, 2,  4'hF, 32'hCAFE0002,  2'b00, 0, 0, 2'b00, 32'h12345678,  32'h0);
    add(0, 0, 0,  4'h0, 32'h0,         2'b11, 2, 2, 2'b11, 32'hCAFE0002,  32'hCAFE0002);
    add(0, 1, 9,  4'hF, 32'h99990009,  2'b00, 0, 0, 2'b00, 32'hCAFE0002,  32'hCAFE0002);
    add(1, 1, 9,  4'hF, 32'h0BADF00D,  2'b11, 0, 0, 2'b00, 32'h0,         32'h0);
    add(0, 0, 0,  4'h0, 32'h0,         2'b10, 0, 9, 2'b10, 32'h0,         32'h99990009);
    add(0, 1, 3,  4'h0, 32'hFFFFFFFF,  2'b00, 0, 0, 2'b00, 32'h0,         32'h99990009);
    add(0, 0, 0,  4'h0, 32'h0,         2'b11, 3, 5, 2'b11, 32'hDEADBEEF,  32'h1122CC44);
    add(0, 1, 0,  4'hF, 32'hA0A0A0A0,  2'b00, 0, 0, 2'b00, 32'hDEADBEEF,  32'h1122CC44);
    add(0, 1, 1,  4'hF, 32'hB1B1B1B1,  2'b00, 0, 0, 2'b00, 32'hDEADBEEF,  32'h1122CC44);
    add(0, 0, 0,  4'h0, 32'h0,         2'b01, 0, 0, 2'b01, 32'hA0A0A0A0,  32'h1122CC44);
    add(0, 0, 0,  4'h0, 32'h0,         2'b00, 1, 0, 2'b00, 32'hA0A0A0A0,  32'h1122CC44);
    add(0, 0, 0,  4'h0, 32'h0,         2'b01, 2, 0, 2'b01, 32'hCAFE0002,  32'h1122CC44);
    add(0, 1, 5,  4'h8, 32'h55FFFFFF,  2'b11, 5, 5, 2'b11, coll5,         coll5);
    add(0, 0, 0,  4'h0, 32'h0,         2'b01, 5, 0, 2'b01, 32'h5522CC44,  coll5);

    for (int i = 0; i < vec.size(); i++) begin
      drive(vec[i].rst, vec[i].we, vec[i].waddr, vec[i].be, vec[i].wdata,
            vec[i].re, vec[i].ra0, vec[i].ra1);
      chk($sformatf("row%0d.valid", i), {30'd0, valid}, {30'd0, vec[i].ev});
      chk($sformatf("row%0d.q0", i), q[31:0], vec[i].eq0);
      chk($sformatf("row%0d.q1", i), q[63:32], vec[i].eq1);
    end

    // Back-to-back reads: one result per cycle on both ports, crossing addresses.
    for (int unsigned i = 0; i < 4; i++) begin
      drive(0, 1, 10'(20 + i), 4'hF, pat(20 + i), 2'b00, 0, 0);
      chk($sformatf("b2b.wr%0d.valid", i), {30'd0, valid}, 32'd0);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      drive(0, 0, 0, 4'h0, 32'h0, 2'b11, 10'(20 + i), 10'(23 - i));
      chk($sformatf("b2b.rd%0d.valid", i), {30'd0, valid}, 32'd3);
      chk($sformatf("b2b.rd%0d.q0", i), q[31:0], pat(20 + i));
      chk($sformatf("b2b.rd%0d.q1", i), q[63:32], pat(23 - i));
    end
    drive(0, 0, 0, 4'h0, 32'h0, 2'b00, 0, 0);
    chk("b2b.idle.valid", {30'd0, valid}, 32'd0);
    chk("b2b.idle.q0", q[31:0], pat(23));
    chk("b2b.idle.q1", q[63:32], pat(20));

    // Reset held two edges, then resume: first valid one cycle after release.
    drive(1, 0, 0, 4'h0, 32'h0, 2'b11, 20, 21);
    drive(1, 0, 0, 4'h0, 32'h0, 2'b11, 20, 21);
    chk("rst2.valid", {30'd0, valid}, 32'd0);
    chk("rst2.q0", q[31:0], 32'd0);
    drive(0, 0, 0, 4'h0, 32'h0, 2'b11, 22, 9);
    chk("resume.valid", {30'd0, valid}, 32'd3);
    chk("resume.q0", q[31:0], pat(22));
    chk("resume.q1", q[63:32], 32'h99990009);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_dp_be.md
RAM_DP_BE -- requirements
Module: ram_dp_be

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word address width; depth = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; must be a multiple of 8.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port ENABLE_W  input  1  write strobe.
REQ-007 SHALL have port ADDR_W  input  ADDR_WIDTH  write word address.
REQ-008 SHALL have port BE_W  input  DATA_WIDTH/8  write byte enables; bit i covers bits 8i+7..8i.
REQ-009 SHALL have port Q_W  input  DATA_WIDTH  write data.
REQ-010 SHALL have port RE_R  input  NUM_RD  per-port read request.
REQ-011 SHALL have port ADDR_R  input  NUM_RD*ADDR_WIDTH  packed read addresses; port p at slice p*ADDR_WIDTH.
REQ-012 SHALL have port Q_R  output  NUM_RD*DATA_WIDTH  packed registered read data, same slicing.
REQ-013 SHALL have port VALID_R  output  NUM_RD  per-port read-data-valid flag.

Function
REQ-014 SHALL write, on rising CLK with ENABLE_W=1 and RESET=0, only bytes of mem[ADDR_W] whose BE_W bit is 1; other bytes unchanged.
REQ-015 SHALL treat ENABLE_W=1 with BE_W=0 as no write.
REQ-016 SHALL, for port p with RE_R[p]=1 at edge N, present mem[ADDR_R[p]] on Q_R[p] and VALID_R[p]=1 after edge N (1-cycle latency).
REQ-017 SHALL, for RE_R[p]=0 at edge N, clear VALID_R[p] and hold Q_R[p] at its previous value.
REQ-018 SHALL serve all NUM_RD ports in the same cycle, including identical addresses, with no stall.
REQ-019 SHALL resolve same-edge read and write to one address per RAM_BYPASS_EN (REQ-025/026), per port independently.
REQ-020 SHALL keep back-to-back reads one result per cycle per port; no internal state machine or busy condition.

Reset
REQ-021 SHALL, while RESET=1 at an edge, drive Q_R to all zeros and VALID_R to all zeros after that edge.
REQ-022 SHALL ignore ENABLE_W and RE_R at any edge where RESET=1; memory contents preserved.
REQ-023 SHALL NOT clear memory contents on reset; contents before first write are undefined.
REQ-024 SHALL resume normal reads on the first edge with RESET=0, first VALID_R one cycle later.

Configuration
REQ-025 SHALL, with macro RAM_BYPASS_EN defined, return write-first data on same-address collision: enabled bytes from Q_W, remaining bytes from old word.
REQ-026 SHALL, without RAM_BYPASS_EN, return read-first (old) word on collision; new data visible from the next read.

Structure
REQ-027 SHALL place BYTE_W=8 constant, max NUM_RD=4 constant and the byte-merge function in shared package ram_pkg.
REQ-028 SHALL instantiate NUM_RD copies of sub-module ram_rd_port, each holding the output register, valid flag and bypass merge.
REQ-029 SHALL reject DATA_WIDTH not a multiple of 8 or NUM_RD outside 1..4 with an elaboration-time error.

Verification
REQ-030 SHALL cover: write addr 3, BE_W=4'hF, Q_W=32'hDEADBEEF; next cycle RE_R[0]=1 addr 3 -> one cycle later Q_R[0]=32'hDEADBEEF, VALID_R[0]=1.
REQ-031 SHALL cover: addr 5 holds 32'h11223344; write BE_W=4'b0010 Q_W=32'hAABBCCDD -> subsequent read returns 32'h1122CC44.
REQ-032 SHALL cover: addr 7 holds 32'h0; same edge write 32'h12345678 BE=4'hF and read addr 7 -> Q_R=32'h12345678 with RAM_BYPASS_EN, 32'h0 without.
REQ-033 SHALL cover: ports 0 and 1 read addr 2 and addr 2 same cycle after write 32'hCAFE0002 -> both Q_R slices 32'hCAFE0002, VALID_R=2'b11.
REQ-034 SHALL cover: RESET=1 for one edge mid-stream with ENABLE_W=1 addr 9 -> Q_R=0, VALID_R=0, and later read of addr 9 returns its pre-reset value.
REQ-035 SHALL cover: RE_R[0] toggled 1,0,1 across addrs 0,1,2 -> VALID_R[0] 1,0,1 and Q_R[0] held during the 0 cycle.
